// File: rtl/sfix_to_fp_pipelined_converter.sv
// Signed fixed-point to binary float converter: 3-stage valid/ready pipeline with
// round-to-nearest-even, overflow saturation or infinity, and flush-to-zero underflow.
module sfix_to_fp_pipelined_converter #(
  parameter int IN_WIDTH   = 22,
  parameter int IN_FRAC    = 12,
  parameter int EXP_WIDTH  = 5,
  parameter int FRAC_WIDTH = 10,
  parameter bit ROUND_EN   = 1'b1,
  parameter bit SAT_EN     = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [IN_WIDTH-1:0]           sfix_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0] fp_o,
  output logic [2:0]                    flags_o,
  output logic                          valid_o,
  input  logic                          ready_i
);
  localparam int STAGES  = 3;
  localparam int BIAS    = 2**(EXP_WIDTH-1) - 1;
  localparam int EXP_MAX = 2**EXP_WIDTH - 1;
  localparam int PW      = $clog2(IN_WIDTH);
  localparam int NW      = IN_WIDTH + FRAC_WIDTH + 1;
  localparam int FPW     = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic                  adv;
  logic [STAGES:1]       vld_pipe_d, vld_pipe_q;
  logic                  s1_sign_d, s1_sign_q;
  logic [IN_WIDTH-1:0]   s1_mag_d, s1_mag_q;
  logic [PW-1:0]         lead;
  logic [NW-1:0]         norm;
  logic                  s2_sign_d, s2_sign_q, s2_zero_d, s2_zero_q;
  logic                  s2_guard_d, s2_guard_q, s2_sticky_d, s2_sticky_q;
  logic [FRAC_WIDTH-1:0] s2_mant_d, s2_mant_q;
  logic signed [31:0]    s2_exp_d, s2_exp_q;
  logic                  inc;
  logic [FRAC_WIDTH:0]   mant_r;
  logic signed [31:0]    exp_r;
  logic [FPW-1:0]        fp_d, fp_q;
  logic [2:0]            flags_d, flags_q;

  assign adv     = !vld_pipe_q[STAGES] || ready_i;
  assign ready_o = adv;
  assign valid_o = vld_pipe_q[STAGES];
  assign fp_o    = fp_q;
  assign flags_o = flags_q;

  // S1: sign/magnitude; the most-negative input maps to 2**(IN_WIDTH-1), still fits
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], valid_i};
      s1_sign_d  = sfix_i[IN_WIDTH-1];
      s1_mag_d   = sfix_i[IN_WIDTH-1] ? -sfix_i : sfix_i;
    end
  end

  // S2: left-justify so the leading one sits in the MSB; zero padding below
  // makes guard/sticky vanish naturally when few bits exist under the leading one
  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      if (s1_mag_q[i]) lead = PW'(i);
    norm = {s1_mag_q, {(FRAC_WIDTH+1){1'b0}}} << (PW'(IN_WIDTH-1) - lead);
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_mant_d   = s2_mant_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    s2_exp_d    = s2_exp_q;
    if (adv) begin
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = !norm[NW-1];
      s2_mant_d   = norm[NW-2 -: FRAC_WIDTH];
      s2_guard_d  = norm[NW-2-FRAC_WIDTH];
      s2_sticky_d = |norm[NW-3-FRAC_WIDTH:0];
      s2_exp_d    = 32'(lead) + 32'(BIAS - IN_FRAC);
    end
  end

  // S3: round, then range-check the post-round exponent
  always_comb begin
    inc     = ROUND_EN && s2_guard_q && (s2_sticky_q || s2_mant_q[0]);
    mant_r  = {1'b0, s2_mant_q} + {{FRAC_WIDTH{1'b0}}, inc};
    exp_r   = s2_exp_q + 32'(mant_r[FRAC_WIDTH]);
    fp_d    = fp_q;
    flags_d = flags_q;
    if (adv) begin
      fp_d    = {s2_sign_q, exp_r[EXP_WIDTH-1:0], mant_r[FRAC_WIDTH-1:0]};
      flags_d = {2'b00, s2_guard_q || s2_sticky_q};
      if (s2_zero_q) begin
        fp_d    = '0;
        flags_d = '0;
      end else if (exp_r >= EXP_MAX) begin
        fp_d = SAT_EN ? {s2_sign_q, EXP_WIDTH'(EXP_MAX-1), {FRAC_WIDTH{1'b1}}}
                      : {s2_sign_q, EXP_WIDTH'(EXP_MAX), {FRAC_WIDTH{1'b0}}};
        flags_d = 3'b101;
      end else if (exp_r <= 0) begin
        fp_d    = {s2_sign_q, {(FPW-1){1'b0}}};
        flags_d = 3'b011;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      fp_q       <= '0;
      flags_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      fp_q       <= fp_d;
      flags_q    <= flags_d;
    end
  end

  always_ff @(posedge clk_i) begin
    s1_sign_q   <= s1_sign_d;
    s1_mag_q    <= s1_mag_d;
    s2_sign_q   <= s2_sign_d;
    s2_zero_q   <= s2_zero_d;
    s2_mant_q   <= s2_mant_d;
    s2_guard_q  <= s2_guard_d;
    s2_sticky_q <= s2_sticky_d;
    s2_exp_q    <= s2_exp_d;
  end
endmodule

// File: tb/tb_sfix_to_fp_pipelined_converter.sv
// Scoreboard bench: two converter instances (default fp16 config, and a wide
// truncating/saturating config that reaches overflow and underflow).
module tb_sfix_to_fp_pipelined_converter;
  localparam int W_A = 22, F_A = 12, W_B = 36, F_B = 18;

  typedef struct { logic [18:0] v; int cyc; bit lat; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [W_A-1:0] sfix_a;
  logic [W_B-1:0] sfix_b;
  logic vin_a, rdy_o_a, vout_a, rdy_i_a, vin_b, rdy_o_b, vout_b, rdy_i_b;
  logic [15:0] fp_a, fp_b;
  logic [2:0] fl_a, fl_b;
  int rmode_a;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  bit held_a = 0, held_b = 0;
  logic [18:0] hold_a, hold_b;

  sfix_to_fp_pipelined_converter #(.IN_WIDTH(W_A), .IN_FRAC(F_A), .EXP_WIDTH(5),
    .FRAC_WIDTH(10), .ROUND_EN(1'b1), .SAT_EN(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .sfix_i(sfix_a), .valid_i(vin_a), .ready_o(rdy_o_a),
    .fp_o(fp_a), .flags_o(fl_a), .valid_o(vout_a), .ready_i(rdy_i_a));

  sfix_to_fp_pipelined_converter #(.IN_WIDTH(W_B), .IN_FRAC(F_B), .EXP_WIDTH(5),
    .FRAC_WIDTH(10), .ROUND_EN(1'b0), .SAT_EN(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .sfix_i(sfix_b), .valid_i(vin_b), .ready_o(rdy_o_b),
    .fp_o(fp_b), .flags_o(fl_b), .valid_o(vout_b), .ready_i(rdy_i_b));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(bit ok, string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: value-level rounding of mag / 2**(p-10), fp16 result {fp,flags}
  function automatic logic [18:0] model(longint x, int f, bit rnd, bit sat);
    longint unsigned mag, q, rem, half;
    int p, sh, be;
    bit s, inx;
    s = (x < 0);
    mag = s ? -x : x;
    if (mag == 0) return '0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    inx = 0;
    if (p > 10) begin
      sh = p - 10;
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      inx = (rem != 0);
      if (rnd && (rem > half || (rem == half && q[0]))) q++;
    end else q = mag << (10 - p);
    be = p - f + 15;
    if (q == 2048) begin q = 1024; be++; end
    if (be >= 31) return {s, sat ? 15'h7BFF : 15'h7C00, 3'b101};
    if (be <= 0) return {s, 15'h0000, 3'b011};
    return {s, 5'(be), 10'(q), 2'b00, inx};
  endfunction

  function automatic longint rnd_x(int w);
    int sh;
    longint r;
    sh = $urandom_range(0, w - 1);
    r = longint'({$urandom, $urandom});
    return r >>> (63 - sh);
  endfunction

  task automatic send_a(logic [W_A-1:0] v, logic [18:0] ev, bit lat);
    int n = 0;
    exp_t t;
    sfix_a = v; vin_a = 1'b1;
    @(negedge clk);
    while (!rdy_o_a && n < 100) begin n++; @(negedge clk); end
    if (!rdy_o_a) chk(1'b0, "send_a_timeout", n, 100);
    else begin t.v = ev; t.cyc = cyc; t.lat = lat; q_a.push_back(t); end
    @(posedge clk); #1;
  endtask

  task automatic send_b(logic [W_B-1:0] v, logic [18:0] ev);
    int n = 0;
    exp_t t;
    sfix_b = v; vin_b = 1'b1;
    @(negedge clk);
    while (!rdy_o_b && n < 100) begin n++; @(negedge clk); end
    if (!rdy_o_b) chk(1'b0, "send_b_timeout", n, 100);
    else begin t.v = ev; t.cyc = cyc; t.lat = 1'b0; q_b.push_back(t); end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #2;
    case (rmode_a)
      0: rdy_i_a = 1'b1;
      1: rdy_i_a = 1'($urandom_range(0, 1));
      default: rdy_i_a = 1'b0;
    endcase
    rdy_i_b = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) held_a = 0;
    else begin
      if (held_a) chk(vout_a && {fp_a, fl_a} == hold_a, "stall_hold_a", {vout_a, fp_a, fl_a}, {1'b1, hold_a});
      held_a = 0;
      if (vout_a && rdy_i_a) begin
        if (q_a.size() == 0) chk(1'b0, "spurious_a", {fp_a, fl_a}, 0);
        else begin
          e_a = q_a.pop_front();
          chk({fp_a, fl_a} == e_a.v, "out_a", {fp_a, fl_a}, e_a.v);
          if (e_a.lat) chk(cyc - e_a.cyc == 3, "latency_a", cyc - e_a.cyc, 3);
        end
      end else if (vout_a) begin held_a = 1; hold_a = {fp_a, fl_a}; end
    end
  end

  always @(negedge clk) begin
    if (rst) held_b = 0;
    else begin
      if (held_b) chk(vout_b && {fp_b, fl_b} == hold_b, "stall_hold_b", {vout_b, fp_b, fl_b}, {1'b1, hold_b});
      held_b = 0;
      if (vout_b && rdy_i_b) begin
        if (q_b.size() == 0) chk(1'b0, "spurious_b", {fp_b, fl_b}, 0);
        else begin
          e_b = q_b.pop_front();
          chk({fp_b, fl_b} == e_b.v, "out_b", {fp_b, fl_b}, e_b.v);
        end
      end else if (vout_b) begin held_b = 1; hold_b = {fp_b, fl_b}; end
    end
  end

  logic [W_A-1:0] dv [8] = '{22'h001000, 22'h3FF000, 22'h000000, 22'h001002,
                             22'h001006, 22'h1FFFFF, 22'h200000, 22'h000001};
  logic [18:0] de [8] = '{{16'h3C00, 3'b000}, {16'hBC00, 3'b000}, {16'h0000, 3'b000},
                          {16'h3C00, 3'b001}, {16'h3C02, 3'b001}, {16'h6000, 3'b001},
                          {16'hE000, 3'b000}, {16'h0C00, 3'b000}};
  longint bv [10] = '{64'sh400000000, -64'sh800000000, 64'sh7FFFFFFFF, 64'sh3FFFFFFFF,
                      64'sd1, -64'sd1, 64'sd8, 64'sd16, 64'sd0, -64'sh123456789};

  task automatic drain(string nm);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin @(posedge clk); n++; end
    chk(q_a.size() == 0 && q_b.size() == 0, nm, q_a.size() + q_b.size(), 0);
    #1;
  endtask

  initial begin
    longint x;
    rst = 1'b1; vin_a = 1'b0; vin_b = 1'b0; sfix_a = '0; sfix_b = '0;
    rmode_a = 0; rdy_i_a = 1'b1; rdy_i_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(vout_a == 1'b0, "rst_valid_a", vout_a, 0);
    chk({fp_a, fl_a} == 19'h0, "rst_out_a", {fp_a, fl_a}, 0);
    chk(vout_b == 1'b0 && {fp_b, fl_b} == 19'h0, "rst_b", {vout_b, fp_b, fl_b}, 0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (dv[i]) send_a(dv[i], de[i], 1'b1);
    vin_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 rmode_a = 1;

    fork
      begin
        for (int k = 0; k < 8; k++) begin
          x = longint'(k) * 37000 - 150000;
          send_a(W_A'(x), model(x, F_A, 1'b1, 1'b0), 1'b0);
        end
        repeat (60) begin
          x = rnd_x(W_A);
          send_a(W_A'(x), model(x, F_A, 1'b1, 1'b0), 1'b0);
        end
        vin_a = 1'b0;
      end
      begin
        foreach (bv[i]) send_b(W_B'(bv[i]), model(bv[i], F_B, 1'b0, 1'b1));
        repeat (60) begin
          x = rnd_x(W_B);
          send_b(W_B'(x), model(x, F_B, 1'b0, 1'b1));
        end
        vin_b = 1'b0;
      end
    join
    drain("drain_stream");

    // Fill the stalled pipeline, then reset it mid-stream
    rmode_a = 2;
    for (int k = 1; k <= 3; k++) send_a(W_A'(k * 4096), model(longint'(k) * 4096, F_A, 1'b1, 1'b0), 1'b0);
    vin_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk(vout_a == 1'b0, "rst_mid_valid", vout_a, 0);
    chk({fp_a, fl_a} == 19'h0, "rst_mid_out", {fp_a, fl_a}, 0);
    q_a.delete();
    rst = 1'b0; rmode_a = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk(vout_a == 1'b0, "no_stale", vout_a, 0);
    end
    @(posedge clk); #1;
    send_a(22'h001000, {16'h3C00, 3'b000}, 1'b1);
    vin_a = 1'b0;
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
